// File: rtl/rf_fifo_ctrl_if.sv
// rtl/rf_fifo_ctrl_if.sv - push/pop request and RegFile control bundle for rf_fifo_ctrl
//
// master : producer/consumer side, drives push, pop, clr_err, observes strobes and status
// slave  : rf_fifo_ctrl, drives wr, rd, AddrWr, AddrRd, full, empty, count, ovf, udf
//          (plus almost_full/almost_empty when RF_FIFO_ALMOST_FLAGS_EN is defined)
interface rf_fifo_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int AS    = $clog2(DEPTH)
);
    logic          push;
    logic          pop;
    logic          clr_err;
    logic          wr;
    logic          rd;
    logic [AS-1:0] AddrWr;
    logic [AS-1:0] AddrRd;
    logic          full;
    logic          empty;
    logic [AS:0]   count;
    logic          ovf;
    logic          udf;
`ifdef RF_FIFO_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    modport master (
        output push, pop, clr_err,
        input  wr, rd, AddrWr, AddrRd, full, empty, count, ovf, udf
`ifdef RF_FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  push, pop, clr_err,
        output wr, rd, AddrWr, AddrRd, full, empty, count, ovf, udf
`ifdef RF_FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/rf_fifo_ctrl.sv
// rtl/rf_fifo_ctrl.sv - circular-FIFO controller for the RegFile register bank
//
// Ports:
//   clk   : master clock, state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : rf_fifo_ctrl_if.slave (push/pop/clr_err in; wr/rd/AddrWr/AddrRd,
//           full/empty/count, sticky ovf/udf out)
// Optional: define RF_FIFO_ALMOST_FLAGS_EN to add AF_LVL/AE_LVL parameters and
//           the almost_full/almost_empty outputs.
module rf_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AS    = $clog2(DEPTH)
`ifdef RF_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 1
`endif
) (
    input logic           clk,
    input logic           reset,
    rf_fifo_ctrl_if.slave bus
);
    localparam logic [AS:0]   CNT_FULL = (AS + 1)'(DEPTH);
    localparam logic [AS-1:0] PTR_LAST = AS'(DEPTH - 1);

    logic [AS-1:0] wr_ptr_q, wr_ptr_d;
    logic [AS-1:0] rd_ptr_q, rd_ptr_d;
    logic [AS:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full;
    logic          empty;
    logic          wr;
    logic          rd;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [AS-1:0] ptr_next(input logic [AS-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
        // A push at full is still accepted when a pop frees the head slot in
        // the same cycle; a pop at empty is never accepted.
        wr    = bus.push & (~full | bus.pop);
        rd    = bus.pop & ~empty;

        wr_ptr_d = wr ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd ? ptr_next(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (wr & ~rd) begin
            count_d = count_q + 1'b1;
        end else if (rd & ~wr) begin
            count_d = count_q - 1'b1;
        end

        // A new error takes priority over clr_err in the same cycle. A pop at
        // empty accompanied by a push is not an underflow: the push is kept.
        ovf_d = (bus.push & ~wr) | (ovf_q & ~bus.clr_err);
        udf_d = (bus.pop & ~rd & ~bus.push) | (udf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus.wr     = wr;
    assign bus.rd     = rd;
    assign bus.AddrWr = wr_ptr_q;
    assign bus.AddrRd = rd_ptr_q;
    assign bus.full   = full;
    assign bus.empty  = empty;
    assign bus.count  = count_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;

`ifdef RF_FIFO_ALMOST_FLAGS_EN
    localparam logic [AS:0] AF_CNT = (AS + 1)'(AF_LVL);
    localparam logic [AS:0] AE_CNT = (AS + 1)'(AE_LVL);

    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
`endif
endmodule

// File: doc/rf_fifo_ctrl.md
Name: rf_fifo_ctrl

Overview:
- FIFO control stage that sits directly upstream of the RegFile register-file bank.
- Converts push/pop requests into the RegFile's wr, rd, AddrWr and AddrRd controls, so the bank behaves as a circular FIFO.
- Tracks occupancy and generates full/empty status plus sticky overflow/underflow error flags.
- Data does not pass through this block: the producer drives RegFile DataIn directly and the consumer samples RegFile DataOut.

Parameters:
- DEPTH, 8, number of RegFile entries; any value >= 2, power of two not required.
- AS, $clog2(DEPTH), address width; must match the RegFile AddrWr/AddrRd width.

Ports:
- clk  input  1  master clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- push  input  1  request to write the word present on RegFile DataIn this cycle.
- pop  input  1  request to read the head word; the word is valid on RegFile DataOut this cycle.
- clr_err  input  1  synchronous clear of the ovf and udf sticky flags.
- wr  output  1  qualified write strobe to RegFile.
- rd  output  1  qualified read strobe to RegFile.
- AddrWr  output  AS  write pointer (tail) to RegFile.
- AddrRd  output  AS  read pointer (head) to RegFile.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AS+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky: a push was dropped.
- udf  output  1  sticky: a pop was dropped.

Behaviour:
- Reset (reset = 0, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, ovf = 0, udf = 0.
  - Resulting outputs: empty = 1, full = 0, AddrWr = 0, AddrRd = 0, wr = 0, rd = 0.
- Reset asserted mid-operation discards all contents with no drain. Operation resumes on the first posedge after reset returns to 1.
- Qualification (combinational, same cycle):
  - wr = push & (~full | pop)
  - rd = pop & ~empty
- AddrWr = wr_ptr and AddrRd = rd_ptr are registered pointers and are driven continuously.
- Read latency: the RegFile drives DataOut while rd = 1, so the popped word is available in the same cycle as pop. The consumer samples it before the next posedge.
- Write latency: the word is stored at the posedge that ends the cycle in which wr = 1. It is readable from the following cycle onward.
- Pointer update at posedge:
  - If wr: wr_ptr <= (wr_ptr == DEPTH-1) ? 0 : wr_ptr + 1.
  - If rd: rd_ptr advances with the same wrap rule.
- Count update at posedge:
  - wr & ~rd: count + 1.
  - rd & ~wr: count - 1.
  - Both or neither: unchanged.
- Simultaneous push and pop:
  - When empty: write only, rd = 0, udf is NOT set; count becomes 1.
  - When full: both proceed. AddrWr equals AddrRd; the old word is read this cycle and the new word is written at the edge; count stays DEPTH.
  - Otherwise: both proceed, count unchanged.
- Boundary cases:
  - Push while full with no pop: wr = 0, state unchanged, ovf <= 1.
  - Pop while empty with no push: rd = 0, state unchanged, udf <= 1.
- Error flags:
  - ovf and udf stay set until clr_err = 1 at a posedge.
  - If clr_err and a new error occur in the same cycle, the flag is set (the set wins).
- full, empty and count are derived from the count register only, so all status is registered and glitch-free.

Optional Feature:
- Macro: RF_FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Adds parameter AF_LVL (default DEPTH-2) and parameter AE_LVL (default 1).
  - Adds output almost_full = (count >= AF_LVL).
  - Adds output almost_empty = (count <= AE_LVL).
  - Both are derived from the count register, with reset values almost_full = 0 and almost_empty = 1.
- When undefined: neither parameter nor either port exists; all other behaviour is identical.

Test Plan:
- Reset, then 8 consecutive pushes with DataIn 0x1..0x8. Required: AddrWr steps 0..7 then wraps to 0; count = 8; full = 1 after the 8th edge; ovf = 0.
- From full, push once more with DataIn 0xF. Required: wr = 0, count stays 8, ovf = 1. Then clr_err for one cycle: ovf = 0.
- From full, 8 pops. Required: DataOut reads 0x1..0x8 in order; AddrRd steps 0..7 then wraps to 0; empty = 1. A 9th pop gives rd = 0 and udf = 1.
- Wrap-around: push 5, pop 5, push 6 (values 0xA..0xF), pop 6. Required: AddrWr runs 5,6,7,0,1,2; data is returned in order; count ends at 0.
- Simultaneous push+pop:
  - At empty: count 0 -> 1, udf stays 0.
  - At full (count 8): count stays 8 and the head word is returned.
  - At count 3: count stays 3.
- Reset pulse low mid-stream at count 5. Required: within the same cycle count = 0, empty = 1, AddrWr = AddrRd = 0, ovf = udf = 0; a following push writes to address 0.
